// File: rtl/usb_tx.sv
// usb_tx: USB 1.1 full-speed transmitter sending SYNC, PID, payload, optional CRC16 and EOP
// with bit stuffing and NRZI. Define USB_TX_CRC16_EN to append a hardware CRC16 to DATA packets.
`timescale 1ns/1ps
module usb_tx #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [3:0] tx_PID,
    input  logic [6:0] byte_count,
    input  logic [7:0] tx_data,
    output logic       get_tx_byte,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, SYNC, PID, DATA,
`ifdef USB_TX_CRC16_EN
        CRC,
`endif
        EOP_SE0, EOP_J
    } state_t;

    state_t        state, state_n;
    logic          start_pend, pend_n;
    logic [3:0]    pid_q, pid_n;
    logic [6:0]    cnt_q, cnt_n;
    logic [15:0]   shreg, sh_n;
    logic [3:0]    bit_idx, idx_n, field_last;
    logic [2:0]    ones, ones_n;
    logic [CW-1:0] clk_cnt, clk_n;
    logic          dp_n, dm_n, busy_n, done_n, err_n;
    logic          emit, emit_bit, pid_is_data, req_is_data;
`ifdef USB_TX_CRC16_EN
    logic [15:0]   crc, crc_n;
    logic          crc_en;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
    endfunction

    // Complemented remainder, reversed so shreg[0] carries the x^15 term first.
    function automatic logic [15:0] crc_wire(input logic [15:0] c);
        logic [15:0] r;
        for (int unsigned i = 0; i < 16; i++) r[i] = ~c[15 - i];
        return r;
    endfunction
`endif

    assign pid_is_data = (pid_q == 4'h3) || (pid_q == 4'hB);
    assign req_is_data = (tx_PID == 4'h3) || (tx_PID == 4'hB);

    always_comb begin
        state_n     = state;
        pend_n      = 1'b0;
        pid_n       = pid_q;
        cnt_n       = cnt_q;
        sh_n        = shreg;
        idx_n       = bit_idx;
        ones_n      = ones;
        clk_n       = clk_cnt;
        dp_n        = d_plus;
        dm_n        = d_minus;
        busy_n      = tx_busy;
        done_n      = 1'b0;
        err_n       = 1'b0;
        get_tx_byte = 1'b0;
        emit        = 1'b0;
        emit_bit    = 1'b0;
`ifdef USB_TX_CRC16_EN
        crc_n      = crc;
        crc_en     = 1'b0;
        field_last = (state == CRC) ? 4'd15 : 4'd7;
`else
        field_last = 4'd7;
`endif
        if (start_pend) begin
            state_n  = SYNC;
            sh_n     = 16'h0080;
            idx_n    = '0;
            clk_n    = '0;
            busy_n   = 1'b1;
            emit     = 1'b1;
            emit_bit = 1'b0;
`ifdef USB_TX_CRC16_EN
            crc_n = '1;
`endif
        end else if (state == IDLE) begin
            if (tx_start) begin
                if (req_is_data && (32'(byte_count) > MAX_BYTES)) begin
                    err_n = 1'b1;
                end else begin
                    pend_n = 1'b1;
                    pid_n  = tx_PID;
                    cnt_n  = byte_count;
                end
            end
        end else if (clk_cnt != LAST_CLK) begin
            clk_n = clk_cnt + 1'b1;
        end else begin
            clk_n = '0;
            case (state)
                EOP_SE0: begin
                    if (bit_idx == 4'd0) begin
                        idx_n = 4'd1;
                    end else begin
                        state_n = EOP_J;
                        dp_n    = 1'b1;
                        dm_n    = 1'b0;
                    end
                end
                EOP_J: begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
                default: begin
                    // Stuffing takes priority, so a pending stuffed 0 also precedes a byte load or EOP.
                    if (ones == 3'd6) begin
                        emit     = 1'b1;
                        emit_bit = 1'b0;
                    end else if (bit_idx != field_last) begin
                        sh_n     = shreg >> 1;
                        idx_n    = bit_idx + 1'b1;
                        emit     = 1'b1;
                        emit_bit = shreg[1];
`ifdef USB_TX_CRC16_EN
                        crc_en = (state == DATA);
`endif
                    end else begin
                        idx_n = '0;
                        if (state == SYNC) begin
                            state_n  = PID;
                            sh_n     = {8'h00, ~pid_q, pid_q};
                            emit     = 1'b1;
                            emit_bit = pid_q[0];
                        end else if ((state == PID || state == DATA) && pid_is_data && cnt_q != 7'd0) begin
                            state_n     = DATA;
                            get_tx_byte = 1'b1;
                            sh_n        = {8'h00, tx_data};
                            cnt_n       = cnt_q - 1'b1;
                            emit        = 1'b1;
                            emit_bit    = tx_data[0];
`ifdef USB_TX_CRC16_EN
                            crc_en = 1'b1;
                        end else if (state != CRC && pid_is_data) begin
                            state_n  = CRC;
                            sh_n     = crc_wire(crc);
                            emit     = 1'b1;
                            emit_bit = ~crc[15];
`endif
                        end else begin
                            state_n = EOP_SE0;
                            dp_n    = 1'b0;
                            dm_n    = 1'b0;
                        end
                    end
                end
            endcase
        end
        if (emit) begin
            dp_n   = emit_bit ? d_plus : ~d_plus;
            dm_n   = ~dp_n;
            ones_n = emit_bit ? ones + 3'd1 : 3'd0;
        end
`ifdef USB_TX_CRC16_EN
        if (crc_en) crc_n = crc_step(crc, emit_bit);
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            start_pend <= 1'b0;
            pid_q      <= '0;
            cnt_q      <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
            ones       <= '0;
            clk_cnt    <= '0;
            d_plus     <= 1'b1;
            d_minus    <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc        <= '0;
`endif
        end else begin
            state      <= state_n;
            start_pend <= pend_n;
            pid_q      <= pid_n;
            cnt_q      <= cnt_n;
            shreg      <= sh_n;
            bit_idx    <= idx_n;
            ones       <= ones_n;
            clk_cnt    <= clk_n;
            d_plus     <= dp_n;
            d_minus    <= dm_n;
            tx_busy    <= busy_n;
            tx_done    <= done_n;
            tx_error   <= err_n;
`ifdef USB_TX_CRC16_EN
            crc        <= crc_n;
`endif
        end
    end
endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: randomized self-checking bench for usb_tx against a byte/bit-level packet model
// (stuffing, NRZI, optional USB_TX_CRC16_EN CRC16) compared cycle by cycle.
`timescale 1ns/1ps
module tb_usb_tx;
    localparam int unsigned CPB  = 8;
    localparam int unsigned MAXB = 64;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic       tx_start;
    logic [3:0] tx_PID;
    logic [6:0] byte_count;
    logic [7:0] tx_data;
    logic       get_tx_byte, d_plus, d_minus, tx_busy, tx_done, tx_error;

    always #5 tb_clk = ~tb_clk;

    usb_tx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
        .clk(tb_clk), .n_rst(n_rst), .tx_start(tx_start), .tx_PID(tx_PID),
        .byte_count(byte_count), .tx_data(tx_data), .get_tx_byte(get_tx_byte),
        .d_plus(d_plus), .d_minus(d_minus), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_error(tx_error)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] fifo[$];
    logic [7:0] pl[$];
    logic [5:0] expv[$];
    logic [5:0] cap[$];
    int         pops;
    int         done_at;

    // Observation vector: {d_plus, d_minus, tx_busy, tx_done, tx_error, get_tx_byte}
    function automatic logic [5:0] obs();
        return {d_plus, d_minus, tx_busy, tx_done, tx_error, get_tx_byte};
    endfunction

    function automatic logic [5:0] expect_at(int t);
        if (t < expv.size()) return expv[t];
        if (t == expv.size()) return 6'b100100;
        return 6'b100000;
    endfunction

    // Index 0 is the cycle after the accepting edge; each symbol then spans CPB cycles.
    task automatic build_model(input logic [3:0] pid);
        logic [7:0]  bytes[$];
        logic [1:0]  bits[$];
        logic [1:0]  st[$];
        logic [15:0] crc;
        logic [5:0]  tmp;
        logic        lvl;
        int          ones, npl;
        npl = (pid == 4'h3 || pid == 4'hB) ? pl.size() : 0;
        bytes = {};
        bytes.push_back(8'h80);
        bytes.push_back({~pid, pid});
        for (int i = 0; i < npl; i++) bytes.push_back(pl[i]);
`ifdef USB_TX_CRC16_EN
        if (pid == 4'h3 || pid == 4'hB) begin
            crc = 16'hFFFF;
            for (int i = 0; i < npl; i++)
                for (int k = 0; k < 8; k++)
                    crc = (crc[0] ^ pl[i][k]) ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
            crc = ~crc;
            bytes.push_back(crc[7:0]);
            bytes.push_back(crc[15:8]);
        end
`else
        crc = 16'h0000;
`endif
        bits = {};
        for (int i = 0; i < bytes.size(); i++)
            for (int k = 0; k < 8; k++)
                bits.push_back({bytes[i][k], (i >= 2 && i < 2 + npl && k == 0)});
        st = {};
        ones = 0;
        for (int i = 0; i < bits.size(); i++) begin
            st.push_back(bits[i]);
            if (bits[i][1]) ones++; else ones = 0;
            if (ones == 6) begin st.push_back(2'b00); ones = 0; end
        end
        expv = {};
        expv.push_back(6'b100000);
        lvl = 1'b1;
        for (int i = 0; i < st.size(); i++) begin
            if (st[i][0]) begin
                tmp = expv.pop_back();
                tmp[0] = 1'b1;
                expv.push_back(tmp);
            end
            if (!st[i][1]) lvl = ~lvl;
            repeat (CPB) expv.push_back({lvl, ~lvl, 4'b1000});
        end
        repeat (2 * CPB) expv.push_back(6'b001000);
        repeat (CPB) expv.push_back(6'b101000);
    endtask

    task automatic run_packet(input logic [3:0] pid, input logic [6:0] cnt, input int limit,
                              input int restart_at, input int abort_at);
        logic pend;
        pend = 1'b0;
        cap = {};
        pops = 0;
        done_at = -1;
        fifo = pl;
        @(negedge tb_clk);
        tx_PID = pid;
        byte_count = cnt;
        tx_start = 1'b1;
        tx_data = (fifo.size() != 0) ? fifo[0] : 8'h00;
        for (int t = 0; t < limit; t++) begin
            @(posedge tb_clk);
            #1;
            tx_start = 1'b0;
            if (pend) begin
                if (fifo.size() != 0) void'(fifo.pop_front());
                pend = 1'b0;
            end
            tx_data = (fifo.size() != 0) ? fifo[0] : 8'h00;
            @(negedge tb_clk);
            cap.push_back(obs());
            if (get_tx_byte) begin pend = 1'b1; pops++; end
            if (tx_done && done_at < 0) done_at = t;
            if (t == restart_at) begin tx_PID = 4'hB; byte_count = 7'd100; tx_start = 1'b1; end
            if (t == abort_at) begin #1 n_rst = 1'b0; break; end
        end
        tx_start = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; tx_start = 1'b0; tx_PID = 4'h0; byte_count = 7'd0; tx_data = 8'h00;
        repeat (3) @(negedge tb_clk);
        vectors++;
        if (obs() !== 6'b100000) begin
            miscompares++; $display("FAIL reset_hold: got %b want %b", obs(), 6'b100000);
        end
        n_rst = 1'b1;
        repeat (3) @(negedge tb_clk);
        vectors++;
        if (obs() !== 6'b100000) begin
            miscompares++; $display("FAIL reset_idle: got %b want %b", obs(), 6'b100000);
        end
    endtask

    task automatic test_ack();
        pl = {};
        build_model(4'h2);
        run_packet(4'h2, 7'd127, expv.size() + 10, -1, -1);
        for (int t = 0; t < cap.size(); t++) begin
            vectors++;
            if (cap[t] !== expect_at(t)) begin
                miscompares++; $display("FAIL ack_line t=%0d: got %b want %b", t, cap[t], expect_at(t));
            end
        end
        vectors++;
        if (pops !== 0) begin miscompares++; $display("FAIL ack_pops: got %0d want 0", pops); end
        vectors++;
        if (done_at !== 153) begin miscompares++; $display("FAIL ack_done_time: got %0d want 153", done_at); end
    endtask

    task automatic test_zero_len();
        pl = {};
        build_model(4'h3);
        run_packet(4'h3, 7'd0, expv.size() + 10, -1, -1);
        for (int t = 0; t < cap.size(); t++) begin
            vectors++;
            if (cap[t] !== expect_at(t)) begin
                miscompares++; $display("FAIL zlen_line t=%0d: got %b want %b", t, cap[t], expect_at(t));
            end
        end
        vectors++;
        if (pops !== 0) begin miscompares++; $display("FAIL zlen_pops: got %0d want 0", pops); end
    endtask

    task automatic test_stuffing();
        pl = {8'hFF, 8'hFF};
        build_model(4'h3);
        run_packet(4'h3, 7'd2, expv.size() + 10, -1, -1);
        for (int t = 0; t < cap.size(); t++) begin
            vectors++;
            if (cap[t] !== expect_at(t)) begin
                miscompares++; $display("FAIL stuff_line t=%0d: got %b want %b", t, cap[t], expect_at(t));
            end
        end
        vectors++;
        if (pops !== 2) begin miscompares++; $display("FAIL stuff_pops: got %0d want 2", pops); end
`ifndef USB_TX_CRC16_EN
        // 35 line bits (3 stuffed, the last after the final payload bit) + 3 EOP bits
        vectors++;
        if (done_at !== 305) begin miscompares++; $display("FAIL stuff_done_time: got %0d want 305", done_at); end
`endif
    endtask

    task automatic test_reject();
        logic [5:0] want;
        for (int c = 0; c < 2; c++) begin
            @(negedge tb_clk);
            tx_PID = (c == 0) ? 4'hB : 4'h3;
            byte_count = (c == 0) ? 7'd65 : 7'd127;
            tx_start = 1'b1;
            @(posedge tb_clk);
            #1 tx_start = 1'b0;
            for (int t = 0; t < 30; t++) begin
                @(negedge tb_clk);
                want = (t == 0) ? 6'b100010 : 6'b100000;
                vectors++;
                if (obs() !== want) begin
                    miscompares++; $display("FAIL reject%0d t=%0d: got %b want %b", c, t, obs(), want);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pid;
        int         len;
        logic [6:0] cnt;
        for (int n = 0; n < 12; n++) begin
            case ($urandom_range(0, 5))
                0: pid = 4'h2;
                1: pid = 4'hA;
                2: pid = 4'h9;
                3: pid = 4'hB;
                default: pid = 4'h3;
            endcase
            if (n == 0) pid = 4'hB;
            pl = {};
            if (pid == 4'h3 || pid == 4'hB) begin
                len = (n == 0) ? MAXB : $urandom_range(0, 20);
                for (int i = 0; i < len; i++)
                    pl.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
                cnt = 7'(len);
            end else begin
                len = 0;
                cnt = 7'($urandom_range(0, 127));
            end
            build_model(pid);
            run_packet(pid, cnt, expv.size() + ((n % 2 == 1) ? 1 : 10), -1, -1);
            for (int t = 0; t < cap.size(); t++) begin
                vectors++;
                if (cap[t] !== expect_at(t)) begin
                    miscompares++;
                    $display("FAIL rand%0d_line pid=%h t=%0d: got %b want %b", n, pid, t, cap[t], expect_at(t));
                end
            end
            vectors++;
            if (pops !== len) begin miscompares++; $display("FAIL rand%0d_pops: got %0d want %0d", n, pops, len); end
        end
    endtask

    task automatic test_busy_ignore();
        pl = {8'($urandom), 8'($urandom), 8'($urandom)};
        build_model(4'hB);
        run_packet(4'hB, 7'd3, expv.size() + 20, 40, -1);
        for (int t = 0; t < cap.size(); t++) begin
            vectors++;
            if (cap[t] !== expect_at(t)) begin
                miscompares++; $display("FAIL busy_line t=%0d: got %b want %b", t, cap[t], expect_at(t));
            end
        end
        vectors++;
        if (pops !== 3) begin miscompares++; $display("FAIL busy_pops: got %0d want 3", pops); end
    endtask

    task automatic test_reset_mid();
        pl = {};
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        build_model(4'h3);
        run_packet(4'h3, 7'd8, 2000, -1, 161);
        #1;
        vectors++;
        if (obs() !== 6'b100000) begin
            miscompares++; $display("FAIL rstmid_async: got %b want %b", obs(), 6'b100000);
        end
        repeat (2) @(negedge tb_clk);
        vectors++;
        if (obs() !== 6'b100000) begin
            miscompares++; $display("FAIL rstmid_hold: got %b want %b", obs(), 6'b100000);
        end
        n_rst = 1'b1;
        pl = {};
        for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
        build_model(4'hB);
        run_packet(4'hB, 7'd4, expv.size() + 10, -1, -1);
        for (int t = 0; t < cap.size(); t++) begin
            vectors++;
            if (cap[t] !== expect_at(t)) begin
                miscompares++; $display("FAIL rstmid_line t=%0d: got %b want %b", t, cap[t], expect_at(t));
            end
        end
        vectors++;
        if (pops !== 4) begin miscompares++; $display("FAIL rstmid_pops: got %0d want 4", pops); end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_zero_len();
        test_stuffing();
        test_reject();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
